// File: rtl/bit_write_controller_pkg.sv
// Shared types and constants for the bit-write control front-end.
// Holds the one-hot FSM state encoding, its bit positions and defaults.
package bit_ctrl_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int IDX_W               = 3;

  localparam int S_INIT     = 0;
  localparam int S_CLR_D1   = 1;
  localparam int S_CLR_D2   = 2;
  localparam int S_IDLE     = 3;
  localparam int S_WR_D2    = 4;
  localparam int S_PUB_D3   = 5;
  localparam int S_WAIT_REL = 6;

  typedef enum logic [6:0] {
    INIT     = 7'b000_0001,
    CLR_D1   = 7'b000_0010,
    CLR_D2   = 7'b000_0100,
    IDLE     = 7'b000_1000,
    WR_D2    = 7'b001_0000,
    PUB_D3   = 7'b010_0000,
    WAIT_REL = 7'b100_0000
  } ctrl_state_t;

endpackage

// File: rtl/bit_write_controller_if.sv
// Button/switch inputs and datapath control outputs of the controller.
// master: controller side; slave: board/datapath side.
interface bit_write_controller_if;
  import bit_ctrl_pkg::*;

  logic             valid_in;
  logic             clear_in;
  logic [IDX_W-1:0] bit_index;
  logic             bit_value;
  logic [IDX_W-1:0] bit_index_q;
  logic             bit_value_q;
  logic             d1_en;
  logic             d2_en;
  logic             d3_en;
  logic             busy;

  modport master (
    input  valid_in, clear_in,
    input  bit_index, bit_value,
    output bit_index_q, bit_value_q,
    output d1_en, d2_en, d3_en, busy
  );

  modport slave (
    output valid_in, clear_in,
    output bit_index, bit_value,
    input  bit_index_q, bit_value_q,
    input  d1_en, d2_en, d3_en, busy
  );

endinterface

// File: rtl/bit_write_controller_debouncer.sv
// Synchroniser + debounce counter + rising-edge register for one button.
// Ports: clk, rst_n, raw (async button) -> level (debounced), rise (pulse).
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   sync;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign level = level_q;
  assign rise  = rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= level_q;
      rise_q <= level_q & ~prev_q;
      // Flip only after a full run of disagreeing cycles.
      if (sync == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_q <= sync;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_write_controller.sv
// Sequences clear/capture/publish enables from debounced button presses.
// Ports: clk, rst_n, bus (master: buttons, switches, enables, busy).
module bit_write_controller
  import bit_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_write_controller_if.master bus
);

  logic wr_level, wr_rise;
  logic cl_level, cl_rise;
  logic load_wr;
  ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic val_q;

  input_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_wr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.valid_in),
    .level (wr_level),
    .rise  (wr_rise)
  );

  input_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_cl_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.clear_in),
    .level (cl_level),
    .rise  (cl_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Requests outside IDLE are dropped; clear beats write.
  always_comb begin
    state_d = state_q;
    load_wr = 1'b0;
    unique case (state_q)
      INIT:     state_d = CLR_D1;
      CLR_D1:   state_d = CLR_D2;
      CLR_D2:   state_d = PUB_D3;
      IDLE: begin
        if (cl_rise) begin
          state_d = CLR_D1;
        end else if (wr_rise) begin
          state_d = WR_D2;
          load_wr = 1'b1;
        end
      end
      WR_D2:    state_d = PUB_D3;
      PUB_D3:   state_d = WAIT_REL;
      WAIT_REL: if (!wr_level && !cl_level) state_d = IDLE;
      default:  state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      val_q <= 1'b0;
    end else if (load_wr) begin
      idx_q <= bus.bit_index;
      val_q <= bus.bit_value;
    end
  end

  assign bus.bit_index_q = idx_q;
  assign bus.bit_value_q = val_q;
  assign bus.d1_en = state_q[S_CLR_D1];
  assign bus.d2_en = state_q[S_CLR_D2] | state_q[S_WR_D2];
  assign bus.d3_en = state_q[S_PUB_D3];
  assign bus.busy  = ~state_q[S_IDLE];

endmodule

// File: tb/tb_bit_write_controller.sv
// Scoreboard bench for bit_write_controller (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Stimulus queues expected enable events; a negedge monitor pops and compares.
module tb_bit_write_controller;
  import bit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_write_controller_if bus();

  bit_write_controller #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] en;
    int         at;
    logic [2:0] idx;
    logic       val;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(logic [2:0] en, int at,
                                    logic [2:0] idx, logic val);
    exp_t e;
    e.en = en;
    e.at = at;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [2:0] en;
    exp_t e;
    en = {bus.d1_en, bus.d2_en, bus.d3_en};
    if (en != 3'b000) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_enable cyc=%0d got en=%b required none",
                 cyc, en);
      end else begin
        e = sb.pop_front();
        if (en !== e.en || cyc != e.at ||
            bus.bit_index_q !== e.idx || bus.bit_value_q !== e.val) begin
          n_err++;
          $display("FAIL enable_event got en=%b cyc=%0d idx=%0d val=%b required en=%b cyc=%0d idx=%0d val=%b",
                   en, cyc, bus.bit_index_q, bus.bit_value_q,
                   e.en, e.at, e.idx, e.val);
        end
      end
    end
  end

  task automatic check(string name, logic [7:0] got, logic [7:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0h required %0h", name, cyc, got, req);
    end
  endtask

  task automatic wait_cyc(int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_d1"}, 8'(bus.d1_en), 8'd0);
    check({tag, "_d2"}, 8'(bus.d2_en), 8'd0);
    check({tag, "_d3"}, 8'(bus.d3_en), 8'd0);
    check({tag, "_busy"}, 8'(bus.busy), 8'd1);
    check({tag, "_idx"}, 8'(bus.bit_index_q), 8'd0);
    check({tag, "_val"}, 8'(bus.bit_value_q), 8'd0);
  endtask

  initial begin
    int r, b, f, g, c, h, d, f2, e, r2;
    bus.valid_in = 1'b0;
    bus.clear_in = 1'b0;
    bus.bit_index = 3'd0;
    bus.bit_value = 1'b0;
    #1;
    check_reset_vals("por");

    // power-on clear
    wait_cyc(3);
    r = cyc;
    rst_n = 1'b1;
    expect_ev(3'b100, r + 1, 3'd0, 1'b0);
    expect_ev(3'b010, r + 2, 3'd0, 1'b0);
    expect_ev(3'b001, r + 3, 3'd0, 1'b0);
    wait_cyc(r + 4);
    check("por_busy_wait", 8'(bus.busy), 8'd1);
    wait_cyc(r + 5);
    check("por_busy_idle", 8'(bus.busy), 8'd0);

    // single write, held then released
    wait_cyc(r + 8);
    b = cyc;
    bus.bit_index = 3'd5;
    bus.bit_value = 1'b1;
    bus.valid_in = 1'b1;
    expect_ev(3'b010, b + 8, 3'd5, 1'b1);
    expect_ev(3'b001, b + 9, 3'd5, 1'b1);
    wait_cyc(b + 7);
    check("wr_busy_pre", 8'(bus.busy), 8'd0);
    wait_cyc(b + 8);
    check("wr_busy_wr", 8'(bus.busy), 8'd1);
    wait_cyc(b + 9);
    bus.bit_index = 3'd7;
    bus.bit_value = 1'b0;
    wait_cyc(b + 20);
    check("wr_busy_held", 8'(bus.busy), 8'd1);
    bus.valid_in = 1'b0;
    f = cyc;
    wait_cyc(f + 6);
    check("rel_busy_pre", 8'(bus.busy), 8'd1);
    wait_cyc(f + 7);
    check("rel_busy_idle", 8'(bus.busy), 8'd0);
    check("wr_idx_hold", 8'(bus.bit_index_q), 8'd5);

    // 3-cycle glitch is filtered
    wait_cyc(f + 10);
    g = cyc;
    bus.valid_in = 1'b1;
    wait_cyc(g + 3);
    bus.valid_in = 1'b0;
    wait_cyc(g + 15);
    check("glitch_busy", 8'(bus.busy), 8'd0);

    // simultaneous clear + write: clear wins
    wait_cyc(g + 20);
    c = cyc;
    bus.bit_index = 3'd2;
    bus.bit_value = 1'b0;
    bus.valid_in = 1'b1;
    bus.clear_in = 1'b1;
    expect_ev(3'b100, c + 8, 3'd5, 1'b1);
    expect_ev(3'b010, c + 9, 3'd5, 1'b1);
    expect_ev(3'b001, c + 10, 3'd5, 1'b1);
    wait_cyc(c + 16);
    bus.valid_in = 1'b0;
    bus.clear_in = 1'b0;
    h = cyc;
    check("clr_idx_hold", 8'(bus.bit_index_q), 8'd5);
    check("clr_val_hold", 8'(bus.bit_value_q), 8'd1);
    wait_cyc(h + 7);
    check("clr_busy_idle", 8'(bus.busy), 8'd0);

    // presses during WAIT_REL are dropped
    wait_cyc(h + 10);
    d = cyc;
    bus.bit_index = 3'd3;
    bus.bit_value = 1'b0;
    bus.valid_in = 1'b1;
    expect_ev(3'b010, d + 8, 3'd3, 1'b0);
    expect_ev(3'b001, d + 9, 3'd3, 1'b0);
    wait_cyc(d + 12);
    bus.clear_in = 1'b1;
    wait_cyc(d + 20);
    bus.valid_in = 1'b0;
    wait_cyc(d + 22);
    bus.valid_in = 1'b1;
    wait_cyc(d + 30);
    check("wrel_busy", 8'(bus.busy), 8'd1);
    bus.valid_in = 1'b0;
    bus.clear_in = 1'b0;
    f2 = cyc;
    wait_cyc(f2 + 10);
    check("wrel_idle", 8'(bus.busy), 8'd0);
    e = cyc;
    bus.bit_index = 3'd6;
    bus.bit_value = 1'b1;
    bus.valid_in = 1'b1;
    expect_ev(3'b010, e + 8, 3'd6, 1'b1);
    expect_ev(3'b001, e + 9, 3'd6, 1'b1);

    // reset in the middle of PUB_D3
    wait_cyc(e + 9);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check_reset_vals("midrst");
    wait_cyc(e + 13);
    r2 = cyc;
    rst_n = 1'b1;
    expect_ev(3'b100, r2 + 1, 3'd0, 1'b0);
    expect_ev(3'b010, r2 + 2, 3'd0, 1'b0);
    expect_ev(3'b001, r2 + 3, 3'd0, 1'b0);
    wait_cyc(r2 + 5);
    check("rst2_busy_idle", 8'(bus.busy), 8'd0);
    wait_cyc(r2 + 10);
    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
